floor_call_scheduler: RTL and testbench



---
 rtl/elevator_pkg.sv | 29 ++
 rtl/call_selector.sv | 75 +++++++
 rtl/floor_call_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_floor_call_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request-side logic.
//   N_FLOORS_DEFAULT : default floor count / one-hot bus width
//   state_t          : scheduler FSM states
//   FLOOR1..FLOOR5   : one-hot floor codes for the default building
//   is_onehot        : true when exactly one bit of the vector is set
package elevator_pkg;

  localparam int N_FLOORS_DEFAULT = 5;

  // Widest floor bus is_onehot accepts; narrower buses are zero-extended.
  localparam int MAX_FLOORS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DWELL  = 2'd2
  } state_t;

  localparam logic [N_FLOORS_DEFAULT-1:0] FLOOR1 = 5'b00001;
  localparam logic [N_FLOORS_DEFAULT-1:0] FLOOR2 = 5'b00010;
  localparam logic [N_FLOORS_DEFAULT-1:0] FLOOR3 = 5'b00100;
  localparam logic [N_FLOORS_DEFAULT-1:0] FLOOR4 = 5'b01000;
  localparam logic [N_FLOORS_DEFAULT-1:0] FLOOR5 = 5'b10000;

  function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/call_selector.sv
// Combinational SCAN pick of the next target floor.
//   pending    : latched outstanding calls, bit i = floor i+1
//   cur_floor  : one-hot current floor
//   dir_up     : current scan direction, 1 = up
//   sel_onehot : chosen floor (one-hot), zero when nothing to serve
//   sel_dir_up : scan direction after this pick
//   sel_valid  : a floor was chosen
module call_selector
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEFAULT
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [N_FLOORS-1:0] cur_floor,
  input  logic                dir_up,
  output logic [N_FLOORS-1:0] sel_onehot,
  output logic                sel_dir_up,
  output logic                sel_valid
);

  logic [N_FLOORS-1:0] below_mask;
  logic [N_FLOORS-1:0] above_mask;
  logic [N_FLOORS-1:0] hit;
  logic [N_FLOORS-1:0] up_cand;
  logic [N_FLOORS-1:0] dn_cand;
  logic [N_FLOORS-1:0] up_pick;
  logic [N_FLOORS-1:0] dn_pick;

  // For a one-hot floor, subtracting one yields every bit below it.
  assign below_mask = cur_floor - N_FLOORS'(1);
  assign above_mask = ~(below_mask | cur_floor);

  assign hit     = pending & cur_floor;
  assign up_cand = pending & above_mask;
  assign dn_cand = pending & below_mask;

  // Nearest call above is the lowest set bit: x & -x isolates it.
  assign up_pick = up_cand & (~up_cand + N_FLOORS'(1));

  // Nearest call below is the highest set bit.
  always_comb begin
    dn_pick = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (dn_cand[i]) begin
        dn_pick    = '0;
        dn_pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_dir_up = dir_up;
    if (|hit) begin
      sel_onehot = hit;
    end else if (dir_up) begin
      if (|up_cand) begin
        sel_onehot = up_pick;
      end else if (|dn_cand) begin
        sel_onehot = dn_pick;
        sel_dir_up = 1'b0;
      end
    end else begin
      if (|dn_cand) begin
        sel_onehot = dn_pick;
      end else if (|up_cand) begin
        sel_onehot = up_pick;
        sel_dir_up = 1'b1;
      end
    end
  end

  assign sel_valid = |sel_onehot;

endmodule

// File: rtl/floor_call_scheduler.sv
// Latches hall/car call buttons, picks the next target floor with a SCAN
// policy and times the door-open dwell at each stop.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   call_btn  : raw asynchronous pushbuttons, bit i = floor i+1
//   cur_floor : one-hot current floor from the floor tracker
//   arrive    : high while the car is at its target (door logic strobe)
//   target    : one-hot selected floor, zero when idle
//   pending   : latched outstanding calls
//   door_open : high during dwell
//   dir_up    : current scan direction, 1 = up
//   busy      : high in MOVING or DWELL
//   err       : registered flag, cur_floor not exactly one-hot
//
// state  | meaning
// IDLE   | no target; dispatches the next pick when calls are pending
// MOVING | target held, waiting for the arrival strobe
// DWELL  | door open, dwell counter running down to zero
module floor_call_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS     = N_FLOORS_DEFAULT,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [N_FLOORS-1:0] cur_floor,
  input  logic                arrive,
  output logic [N_FLOORS-1:0] target,
  output logic [N_FLOORS-1:0] pending,
  output logic                door_open,
  output logic                dir_up,
  output logic                busy,
  output logic                err
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0][N_FLOORS-1:0] sync_q;
  logic [N_FLOORS-1:0] btn_prev;
  logic [N_FLOORS-1:0] rise;
  logic [N_FLOORS-1:0] latch_mask;
  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;
  logic [N_FLOORS-1:0] target_q;
  logic                dir_up_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [N_FLOORS-1:0] sel_onehot;
  logic                sel_dir_up;
  logic                sel_valid;

  logic cur_ok;
  logic dispatch;
  logic do_arrive;
  logic reload;
  logic dwell_done;

  // Button synchronizer plus the previous-value register for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      btn_prev <= '0;
    end else begin
      sync_q[0] <= call_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      btn_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~btn_prev;

  assign cur_ok = is_onehot(MAX_FLOORS'(cur_floor));

  call_selector #(
    .N_FLOORS (N_FLOORS)
  ) u_call_selector (
    .pending    (pending_q),
    .cur_floor  (cur_floor),
    .dir_up     (dir_up_q),
    .sel_onehot (sel_onehot),
    .sel_dir_up (sel_dir_up),
    .sel_valid  (sel_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cur_ok also gates dispatch so a floor bus that just went bad cannot
  // slip a dispatch through in the cycle before err registers it.
  always_comb begin
    state_d    = state_q;
    dispatch   = 1'b0;
    do_arrive  = 1'b0;
    reload     = 1'b0;
    dwell_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid && cur_ok && !err_q) begin
          dispatch = 1'b1;
          state_d  = MOVING;
        end
      end
      MOVING: begin
        if (arrive && !err_q) begin
          do_arrive = 1'b1;
          state_d   = DWELL;
        end
      end
      DWELL: begin
        if (|(rise & cur_floor)) begin
          reload = 1'b1;
        end else if (cnt_q == '0) begin
          dwell_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    door_open = (state_q == DWELL);
  end

  // A press at the open-door floor only extends the dwell; an arrival clear
  // beats a same-cycle press of that floor.
  always_comb begin
    latch_mask = rise;
    if (state_q == DWELL) begin
      latch_mask = rise & ~cur_floor;
    end
    pending_d = pending_q | latch_mask;
    if (do_arrive) begin
      pending_d = pending_d & ~cur_floor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      target_q  <= '0;
      dir_up_q  <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= ~cur_ok;
      if (dispatch) begin
        target_q <= sel_onehot;
        dir_up_q <= sel_dir_up;
      end else if (dwell_done) begin
        target_q <= '0;
      end
      if (do_arrive || reload) begin
        cnt_q <= DWELL_LOAD;
      end else if ((state_q == DWELL) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign target  = target_q;
  assign pending = pending_q;
  assign dir_up  = dir_up_q;
  assign err     = err_q;

endmodule

// File: tb/tb_floor_call_scheduler.sv
// Self-checking bench for floor_call_scheduler (DWELL_CYCLES = 8) plus a
// standalone random check of call_selector against an index-based model.
module tb_floor_call_scheduler;

  logic       clk;
  logic       rst_n;
  logic [4:0] call_btn;
  logic [4:0] cur_floor;
  logic       arrive;
  logic [4:0] target;
  logic [4:0] pending;
  logic       door_open;
  logic       dir_up;
  logic       busy;
  logic       err;

  logic [4:0] s_pend;
  logic [4:0] s_cur;
  logic       s_dir;
  logic [4:0] s_sel;
  logic       s_sel_dir;
  logic       s_valid;

  int n_err;
  int n_chk;

  // {dir_up, target} expected at each dispatch, in order
  logic [5:0] exp_q[$];

  floor_call_scheduler #(
    .N_FLOORS     (5),
    .DWELL_CYCLES (8),
    .CNT_W        (4),
    .SYNC_STAGES  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .call_btn  (call_btn),
    .cur_floor (cur_floor),
    .arrive    (arrive),
    .target    (target),
    .pending   (pending),
    .door_open (door_open),
    .dir_up    (dir_up),
    .busy      (busy),
    .err       (err)
  );

  call_selector #(
    .N_FLOORS (5)
  ) u_sel (
    .pending    (s_pend),
    .cur_floor  (s_cur),
    .dir_up     (s_dir),
    .sel_onehot (s_sel),
    .sel_dir_up (s_sel_dir),
    .sel_valid  (s_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference SCAN pick by floor index; returns {valid, dir, sel}.
  function automatic logic [6:0] sel_model(input logic [4:0] p, input logic [4:0] c, input logic d);
    int ci, up, dn;
    logic [4:0] s;
    logic nd;
    ci = 0;
    for (int i = 0; i < 5; i++) if (c[i]) ci = i;
    s  = '0;
    nd = d;
    up = -1;
    dn = -1;
    for (int i = 4; i > ci; i--) if (p[i]) up = i;
    for (int i = 0; i < ci; i++) if (p[i]) dn = i;
    if (p[ci]) s[ci] = 1'b1;
    else if (d) begin
      if (up >= 0) s[up] = 1'b1;
      else if (dn >= 0) begin s[dn] = 1'b1; nd = 1'b0; end
    end else begin
      if (dn >= 0) s[dn] = 1'b1;
      else if (up >= 0) begin s[up] = 1'b1; nd = 1'b1; end
    end
    return {(s != 5'b0), nd, s};
  endfunction

  // Scoreboard: every 0 -> nonzero change of target is a dispatch.
  initial begin
    logic [4:0] prev_t;
    logic [5:0] e;
    prev_t = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (target != 5'b0) && (prev_t == 5'b0)) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected", 32'(target), 0);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_target", 32'(target), 32'(e[4:0]));
          check_val("sb_dir", 32'(dir_up), 32'(e[5]));
        end
      end
      prev_t = target;
    end
  end

  task automatic press_latch(input logic [4:0] b, input logic [4:0] exp_pend);
    call_btn = b;
    repeat (3) @(negedge clk);
    check_val("pend_latch", 32'(pending), 32'(exp_pend));
    call_btn = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_reached", 32'(busy), 0);
  endtask

  task automatic wait_dispatch();
    int n;
    n = 0;
    while ((target == 5'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("dispatch_seen", 32'(target != 5'b0), 1);
  endtask

  task automatic serve(input logic [4:0] fl);
    cur_floor = fl;
    arrive    = 1'b1;
    @(negedge clk);
    arrive = 1'b0;
    check_val("door_on_arrive", 32'(door_open), 1);
    wait_idle();
  endtask

  // Counts cycles with door_open high from the current one; optionally
  // presses btn at loop index press_at and releases it four cycles later.
  task automatic count_open(input int press_at, input logic [4:0] btn, output int cnt);
    int i;
    cnt = 0;
    i   = 0;
    while (door_open && i < 40) begin
      if (i == press_at) call_btn = btn;
      if (i == press_at + 4) call_btn = '0;
      cnt++;
      i++;
      @(negedge clk);
    end
    call_btn = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [6:0] m;
    n_err     = 0;
    n_chk     = 0;
    rst_n     = 1'b0;
    call_btn  = '0;
    cur_floor = 5'b00001;
    arrive    = 1'b0;

    // Standalone selector against the index model.
    for (int k = 0; k < 64; k++) begin
      s_pend = 5'($urandom_range(0, 31));
      s_cur  = 5'b00001 << $urandom_range(0, 4);
      s_dir  = 1'($urandom_range(0, 1));
      #1;
      m = sel_model(s_pend, s_cur, s_dir);
      check_val("selector", {25'b0, s_valid, s_sel_dir, s_sel}, 32'(m));
    end

    // 1: reset values, press floor 3 from floor 1
    @(negedge clk);
    check_val("rst_target", 32'(target), 0);
    check_val("rst_pending", 32'(pending), 0);
    check_val("rst_door", 32'(door_open), 0);
    check_val("rst_dir", 32'(dir_up), 1);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({1'b1, 5'b00100});
    call_btn = 5'b00100;
    repeat (2) @(negedge clk);
    check_val("pend_early", 32'(pending), 0);
    @(negedge clk);
    check_val("pend_f3", 32'(pending), 'b00100);
    check_val("target_pre", 32'(target), 0);
    @(negedge clk);
    check_val("target_f3", 32'(target), 'b00100);
    check_val("busy_f3", 32'(busy), 1);
    check_val("dir_f3", 32'(dir_up), 1);
    call_btn = '0;

    // 2: arrive at floor 3, 8-cycle dwell
    cur_floor = 5'b00100;
    arrive    = 1'b1;
    @(negedge clk);
    arrive = 1'b0;
    check_val("pend_cleared", 32'(pending), 0);
    check_val("door_open_f3", 32'(door_open), 1);
    count_open(-1, 5'b0, cnt);
    check_val("dwell_len", 32'(cnt), 8);
    check_val("target_after_dwell", 32'(target), 0);
    check_val("busy_after_dwell", 32'(busy), 0);

    // 3: at floor 3 going up, calls at 5 and 2: 5 first, then 2 going down
    exp_q.push_back({1'b1, 5'b10000});
    exp_q.push_back({1'b0, 5'b00010});
    press_latch(5'b10010, 5'b10010);
    wait_dispatch();
    check_val("target_f5", 32'(target), 'b10000);
    check_val("dir_f5", 32'(dir_up), 1);
    serve(5'b10000);
    check_val("pend_after_f5", 32'(pending), 'b00010);
    wait_dispatch();
    check_val("target_f2", 32'(target), 'b00010);
    check_val("dir_f2", 32'(dir_up), 0);
    serve(5'b00010);

    // 4: dwell at floor 3 extended by a press of floor 3 at count 2
    exp_q.push_back({1'b1, 5'b00100});
    press_latch(5'b00100, 5'b00100);
    wait_dispatch();
    cur_floor = 5'b00100;
    arrive    = 1'b1;
    @(negedge clk);
    arrive = 1'b0;
    check_val("door_open_f3b", 32'(door_open), 1);
    count_open(3, 5'b00100, cnt);
    check_val("dwell_reload_len", 32'(cnt), 14);
    check_val("pend_f3_masked", 32'(pending), 0);
    check_val("idle_after_reload", 32'(busy), 0);

    // 5: floor 4 press coincides with its arrival clear; floor 1 latches
    exp_q.push_back({1'b1, 5'b01000});
    press_latch(5'b01000, 5'b01000);
    wait_dispatch();
    repeat (4) @(negedge clk);
    call_btn = 5'b01001;
    repeat (2) @(negedge clk);
    cur_floor = 5'b01000;
    arrive    = 1'b1;
    @(negedge clk);
    arrive   = 1'b0;
    call_btn = '0;
    check_val("pend_clear_wins", 32'(pending), 'b00001);
    check_val("door_open_f4", 32'(door_open), 1);
    exp_q.push_back({1'b0, 5'b00001});
    wait_idle();
    wait_dispatch();
    serve(5'b00001);

    // 6: bad floor bus blocks dispatch; reset mid-dwell
    cur_floor = 5'b00110;
    @(negedge clk);
    check_val("err_set", 32'(err), 1);
    press_latch(5'b00001, 5'b00001);
    repeat (2) @(negedge clk);
    check_val("err_no_dispatch", 32'(target), 0);
    check_val("err_not_busy", 32'(busy), 0);
    exp_q.push_back({1'b0, 5'b00001});
    cur_floor = 5'b00100;
    @(negedge clk);
    check_val("err_clear", 32'(err), 0);
    check_val("target_wait", 32'(target), 0);
    @(negedge clk);
    check_val("target_after_err", 32'(target), 'b00001);
    check_val("busy_after_err", 32'(busy), 1);
    cur_floor = 5'b00001;
    arrive    = 1'b1;
    @(negedge clk);
    arrive = 1'b0;
    check_val("door_open_f1", 32'(door_open), 1);
    press_latch(5'b10000, 5'b10000);
    check_val("dir_before_rst", 32'(dir_up), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_target", 32'(target), 0);
    check_val("mid_rst_pending", 32'(pending), 0);
    check_val("mid_rst_door", 32'(door_open), 0);
    check_val("mid_rst_dir", 32'(dir_up), 1);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_target", 32'(target), 0);
    check_val("post_rst_pending", 32'(pending), 0);
    check_val("sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
